// File: rtl/alu_issue_station_pkg.sv
// Shared widths, instruction-type codes and payload structs for the ALU
// reservation station.
package alu_issue_station_pkg;

  localparam int unsigned RS_SIZE = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned ROB_W   = 4;
  localparam int unsigned TYPE_W  = 6;

  // Instruction-type codes handled by the integer ALU
  localparam logic [TYPE_W-1:0] TYPE_ADD  = 6'd1;
  localparam logic [TYPE_W-1:0] TYPE_SUB  = 6'd2;
  localparam logic [TYPE_W-1:0] TYPE_ADDI = 6'd3;
  localparam logic [TYPE_W-1:0] TYPE_BEQ  = 6'd4;
  localparam logic [TYPE_W-1:0] TYPE_JAL  = 6'd5;
  localparam logic [TYPE_W-1:0] TYPE_JALR = 6'd6;

  // One station slot
  typedef struct packed {
    logic              valid;
    logic              qj_busy;
    logic              qk_busy;
    logic [ROB_W-1:0]  qj;
    logic [ROB_W-1:0]  qk;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [DATA_W-1:0] a;
    logic [ROB_W-1:0]  dest;
    logic [ADDR_W-1:0] pc;
    logic [TYPE_W-1:0] inst_type;
  } rs_entry_t;

  // Issue payload presented to the ALU
  typedef struct packed {
    logic              en;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [DATA_W-1:0] a;
    logic [ROB_W-1:0]  dest;
    logic [ADDR_W-1:0] pc;
    logic [TYPE_W-1:0] inst_type;
  } rs_issue_t;

  // True when a valid CDB broadcast carries the given tag
  function automatic logic cdb_hit(input logic en, input logic [ROB_W-1:0] bus_tag,
                                   input logic [ROB_W-1:0] tag);
    return en && (bus_tag == tag);
  endfunction

endpackage

// File: rtl/alu_issue_station_if.sv
// Dispatch, CDB snoop, flush and ALU-issue signals of the reservation station.
//   master: dispatcher / CDB / ROB side (drives dispatch, cdb, flush)
//   slave : the station (drives rs_full_out and the rs_* issue outputs)
interface alu_issue_station_if;
  import alu_issue_station_pkg::*;

  logic              dispatch_en_in;
  logic [DATA_W-1:0] dispatch_vj_in;
  logic [DATA_W-1:0] dispatch_vk_in;
  logic              dispatch_qj_busy_in;
  logic              dispatch_qk_busy_in;
  logic [ROB_W-1:0]  dispatch_qj_in;
  logic [ROB_W-1:0]  dispatch_qk_in;
  logic [DATA_W-1:0] dispatch_A_in;
  logic [ROB_W-1:0]  dispatch_dest_in;
  logic [ADDR_W-1:0] dispatch_pc_in;
  logic [TYPE_W-1:0] dispatch_inst_type_in;

  logic              cdb_alu_en_in;
  logic [ROB_W-1:0]  cdb_alu_dest_in;
  logic [DATA_W-1:0] cdb_alu_value_in;
  logic              cdb_lsb_en_in;
  logic [ROB_W-1:0]  cdb_lsb_dest_in;
  logic [DATA_W-1:0] cdb_lsb_value_in;

  logic              rob_flush_in;

  logic              rs_full_out;
  logic              rs_en_out;
  logic [DATA_W-1:0] rs_vj_out;
  logic [DATA_W-1:0] rs_vk_out;
  logic [DATA_W-1:0] rs_A_out;
  logic [ROB_W-1:0]  rs_dest_out;
  logic [ADDR_W-1:0] rs_pc_out;
  logic [TYPE_W-1:0] rs_inst_type_out;

  modport master (
    output dispatch_en_in, dispatch_vj_in, dispatch_vk_in, dispatch_qj_busy_in,
           dispatch_qk_busy_in, dispatch_qj_in, dispatch_qk_in, dispatch_A_in,
           dispatch_dest_in, dispatch_pc_in, dispatch_inst_type_in,
           cdb_alu_en_in, cdb_alu_dest_in, cdb_alu_value_in,
           cdb_lsb_en_in, cdb_lsb_dest_in, cdb_lsb_value_in, rob_flush_in,
    input  rs_full_out, rs_en_out, rs_vj_out, rs_vk_out, rs_A_out, rs_dest_out,
           rs_pc_out, rs_inst_type_out
  );

  modport slave (
    input  dispatch_en_in, dispatch_vj_in, dispatch_vk_in, dispatch_qj_busy_in,
           dispatch_qk_busy_in, dispatch_qj_in, dispatch_qk_in, dispatch_A_in,
           dispatch_dest_in, dispatch_pc_in, dispatch_inst_type_in,
           cdb_alu_en_in, cdb_alu_dest_in, cdb_alu_value_in,
           cdb_lsb_en_in, cdb_lsb_dest_in, cdb_lsb_value_in, rob_flush_in,
    output rs_full_out, rs_en_out, rs_vj_out, rs_vk_out, rs_A_out, rs_dest_out,
           rs_pc_out, rs_inst_type_out
  );

endinterface

// File: rtl/rs_priority_select.sv
// Lowest-set-bit finder used for free-slot allocation and issue selection.
//   req_i     : request vector
//   found_c_o : any bit set (combinational)
//   idx_c_o   : index of the lowest set bit, 0 when none (combinational)
module rs_priority_select
  import alu_issue_station_pkg::*;
#(
  parameter int unsigned N = RS_SIZE,
  parameter int unsigned W = IDX_W
) (
  input  logic [N-1:0] req_i,
  output logic         found_c_o,
  output logic [W-1:0] idx_c_o
);

  // Scan from the top so the lowest set bit is the last one written
  always_comb begin
    found_c_o = 1'b0;
    idx_c_o   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_c_o = 1'b1;
        idx_c_o   = W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_issue_station.sv
// Reservation station feeding the single integer ALU. Holds dispatched ops,
// snoops the ALU and LSB CDB buses to resolve operand tags, and issues at most
// one operand-ready entry per cycle through registered rs_* outputs.
//   clk_in, rst_n_in : clock, async active-low reset
//   rdy_in           : global ready, low freezes all state
//   bus (slave)      : dispatch inputs, CDB snoop, flush, rs_full_out and
//                      the registered issue outputs
module alu_issue_station
  import alu_issue_station_pkg::*;
(
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic rdy_in,
  alu_issue_station_if.slave bus
);

  rs_entry_t entry_q [RS_SIZE];
  rs_entry_t entry_d [RS_SIZE];
  rs_issue_t issue_q;
  rs_issue_t issue_d;
  rs_entry_t new_entry_c;

  logic [RS_SIZE-1:0] valid_vec_c;
  logic [RS_SIZE-1:0] ready_vec_c;
  logic               free_found_c;
  logic [IDX_W-1:0]   free_idx_c;
  logic               ready_found_c;
  logic [IDX_W-1:0]   ready_idx_c;

  // Occupancy and readiness from registered state only
  always_comb begin
    valid_vec_c = '0;
    ready_vec_c = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      valid_vec_c[i] = entry_q[i].valid;
      ready_vec_c[i] = entry_q[i].valid && !entry_q[i].qj_busy && !entry_q[i].qk_busy;
    end
  end

  rs_priority_select #(.N(RS_SIZE), .W(IDX_W)) u_free_sel (
    .req_i     (~valid_vec_c),
    .found_c_o (free_found_c),
    .idx_c_o   (free_idx_c)
  );

  rs_priority_select #(.N(RS_SIZE), .W(IDX_W)) u_ready_sel (
    .req_i     (ready_vec_c),
    .found_c_o (ready_found_c),
    .idx_c_o   (ready_idx_c)
  );

  // Incoming entry with same-cycle CDB bypass; the ALU bus takes precedence
  always_comb begin
    new_entry_c           = '0;
    new_entry_c.valid     = 1'b1;
    new_entry_c.vj        = bus.dispatch_vj_in;
    new_entry_c.vk        = bus.dispatch_vk_in;
    new_entry_c.qj_busy   = bus.dispatch_qj_busy_in;
    new_entry_c.qk_busy   = bus.dispatch_qk_busy_in;
    new_entry_c.qj        = bus.dispatch_qj_in;
    new_entry_c.qk        = bus.dispatch_qk_in;
    new_entry_c.a         = bus.dispatch_A_in;
    new_entry_c.dest      = bus.dispatch_dest_in;
    new_entry_c.pc        = bus.dispatch_pc_in;
    new_entry_c.inst_type = bus.dispatch_inst_type_in;
    if (bus.dispatch_qj_busy_in) begin
      if (cdb_hit(bus.cdb_alu_en_in, bus.cdb_alu_dest_in, bus.dispatch_qj_in)) begin
        new_entry_c.vj      = bus.cdb_alu_value_in;
        new_entry_c.qj_busy = 1'b0;
      end else if (cdb_hit(bus.cdb_lsb_en_in, bus.cdb_lsb_dest_in, bus.dispatch_qj_in)) begin
        new_entry_c.vj      = bus.cdb_lsb_value_in;
        new_entry_c.qj_busy = 1'b0;
      end
    end
    if (bus.dispatch_qk_busy_in) begin
      if (cdb_hit(bus.cdb_alu_en_in, bus.cdb_alu_dest_in, bus.dispatch_qk_in)) begin
        new_entry_c.vk      = bus.cdb_alu_value_in;
        new_entry_c.qk_busy = 1'b0;
      end else if (cdb_hit(bus.cdb_lsb_en_in, bus.cdb_lsb_dest_in, bus.dispatch_qk_in)) begin
        new_entry_c.vk      = bus.cdb_lsb_value_in;
        new_entry_c.qk_busy = 1'b0;
      end
    end
  end

  // Next state: wakeup, issue, allocation, then flush overriding all of them.
  // Issue only picks ready entries and allocation only free ones, so the three
  // never touch the same slot.
  always_comb begin
    entry_d    = entry_q;
    issue_d    = issue_q;
    issue_d.en = 1'b0;

    for (int i = 0; i < int'(RS_SIZE); i++) begin
      if (entry_q[i].valid && entry_q[i].qj_busy) begin
        if (cdb_hit(bus.cdb_alu_en_in, bus.cdb_alu_dest_in, entry_q[i].qj)) begin
          entry_d[i].vj      = bus.cdb_alu_value_in;
          entry_d[i].qj_busy = 1'b0;
        end else if (cdb_hit(bus.cdb_lsb_en_in, bus.cdb_lsb_dest_in, entry_q[i].qj)) begin
          entry_d[i].vj      = bus.cdb_lsb_value_in;
          entry_d[i].qj_busy = 1'b0;
        end
      end
      if (entry_q[i].valid && entry_q[i].qk_busy) begin
        if (cdb_hit(bus.cdb_alu_en_in, bus.cdb_alu_dest_in, entry_q[i].qk)) begin
          entry_d[i].vk      = bus.cdb_alu_value_in;
          entry_d[i].qk_busy = 1'b0;
        end else if (cdb_hit(bus.cdb_lsb_en_in, bus.cdb_lsb_dest_in, entry_q[i].qk)) begin
          entry_d[i].vk      = bus.cdb_lsb_value_in;
          entry_d[i].qk_busy = 1'b0;
        end
      end
    end

    if (ready_found_c) begin
      issue_d.en                = 1'b1;
      issue_d.vj                = entry_q[ready_idx_c].vj;
      issue_d.vk                = entry_q[ready_idx_c].vk;
      issue_d.a                 = entry_q[ready_idx_c].a;
      issue_d.dest              = entry_q[ready_idx_c].dest;
      issue_d.pc                = entry_q[ready_idx_c].pc;
      issue_d.inst_type         = entry_q[ready_idx_c].inst_type;
      entry_d[ready_idx_c].valid = 1'b0;
    end

    // A dispatch while full finds no free slot and is dropped
    if (bus.dispatch_en_in && free_found_c) begin
      entry_d[free_idx_c] = new_entry_c;
    end

    if (bus.rob_flush_in) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        entry_d[i].valid = 1'b0;
      end
      issue_d    = issue_q;
      issue_d.en = 1'b0;
    end
  end

  // State registers; rdy_in low freezes everything
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        entry_q[i] <= '0;
      end
      issue_q <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        entry_q[i] <= entry_d[i];
      end
      issue_q <= issue_d;
    end
  end

  assign bus.rs_full_out      = &valid_vec_c;
  assign bus.rs_en_out        = issue_q.en;
  assign bus.rs_vj_out        = issue_q.vj;
  assign bus.rs_vk_out        = issue_q.vk;
  assign bus.rs_A_out         = issue_q.a;
  assign bus.rs_dest_out      = issue_q.dest;
  assign bus.rs_pc_out        = issue_q.pc;
  assign bus.rs_inst_type_out = issue_q.inst_type;

endmodule

// File: tb/tb_alu_issue_station.sv
// Directed self-checking bench for alu_issue_station.
module tb_alu_issue_station;
  import alu_issue_station_pkg::*;

  logic clk_in;
  logic rst_n_in;
  logic rdy_in;
  int   n_tests;
  int   n_fail;

  alu_issue_station_if bus ();

  alu_issue_station dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .rdy_in   (rdy_in),
    .bus      (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Advance one edge and land 1 time unit after it
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    bus.dispatch_en_in        = 1'b0;
    bus.dispatch_vj_in        = '0;
    bus.dispatch_vk_in        = '0;
    bus.dispatch_qj_busy_in   = 1'b0;
    bus.dispatch_qk_busy_in   = 1'b0;
    bus.dispatch_qj_in        = '0;
    bus.dispatch_qk_in        = '0;
    bus.dispatch_A_in         = '0;
    bus.dispatch_dest_in      = '0;
    bus.dispatch_pc_in        = '0;
    bus.dispatch_inst_type_in = '0;
    bus.cdb_alu_en_in         = 1'b0;
    bus.cdb_alu_dest_in       = '0;
    bus.cdb_alu_value_in      = '0;
    bus.cdb_lsb_en_in         = 1'b0;
    bus.cdb_lsb_dest_in       = '0;
    bus.cdb_lsb_value_in      = '0;
    bus.rob_flush_in          = 1'b0;
  endtask

  task automatic drive_dispatch(input logic [31:0] vj, input logic [31:0] vk,
                                input logic qjb, input logic [3:0] qj,
                                input logic qkb, input logic [3:0] qk,
                                input logic [31:0] a, input logic [3:0] dest,
                                input logic [31:0] pc, input logic [5:0] t);
    bus.dispatch_en_in        = 1'b1;
    bus.dispatch_vj_in        = vj;
    bus.dispatch_vk_in        = vk;
    bus.dispatch_qj_busy_in   = qjb;
    bus.dispatch_qj_in        = qj;
    bus.dispatch_qk_busy_in   = qkb;
    bus.dispatch_qk_in        = qk;
    bus.dispatch_A_in         = a;
    bus.dispatch_dest_in      = dest;
    bus.dispatch_pc_in        = pc;
    bus.dispatch_inst_type_in = t;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    rdy_in   = 1'b1;
    idle_inputs();
    #12;
    rst_n_in = 1'b1;
    step();
    n_tests++;
    if (bus.rs_en_out !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %0b exp 0", bus.rs_en_out); end
    n_tests++;
    if (bus.rs_full_out !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b exp 0", bus.rs_full_out); end
    n_tests++;
    if (bus.rs_vj_out !== 32'd0 || bus.rs_dest_out !== 4'd0 || bus.rs_pc_out !== 32'd0)
      begin n_fail++; $display("FAIL reset_data: vj %h dest %h pc %h exp 0", bus.rs_vj_out, bus.rs_dest_out, bus.rs_pc_out); end
  endtask

  task automatic test_add();
    drive_dispatch(32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd3, 32'h40, TYPE_ADD);
    step();
    idle_inputs();
    n_tests++;
    if (bus.rs_en_out !== 1'b0) begin n_fail++; $display("FAIL add_early: got %0b exp 0", bus.rs_en_out); end
    step();
    n_tests++;
    if (bus.rs_en_out !== 1'b1) begin n_fail++; $display("FAIL add_en: got %0b exp 1", bus.rs_en_out); end
    n_tests++;
    if (bus.rs_vj_out !== 32'd5 || bus.rs_vk_out !== 32'd7)
      begin n_fail++; $display("FAIL add_ops: vj %0d vk %0d exp 5 7", bus.rs_vj_out, bus.rs_vk_out); end
    n_tests++;
    if (bus.rs_dest_out !== 4'd3 || bus.rs_inst_type_out !== TYPE_ADD || bus.rs_pc_out !== 32'h40)
      begin n_fail++; $display("FAIL add_tag: dest %0d type %0d pc %h exp 3 %0d 40", bus.rs_dest_out, bus.rs_inst_type_out, bus.rs_pc_out, TYPE_ADD); end
    step();
    n_tests++;
    if (bus.rs_en_out !== 1'b0) begin n_fail++; $display("FAIL add_drop: got %0b exp 0", bus.rs_en_out); end
    n_tests++;
    if (bus.rs_vj_out !== 32'd5) begin n_fail++; $display("FAIL add_hold: vj %0d exp 5", bus.rs_vj_out); end
  endtask

  task automatic test_wakeup();
    drive_dispatch(32'd0, 32'd0, 1'b1, 4'd6, 1'b0, 4'd0, 32'd10, 4'd4, 32'h100, TYPE_ADDI);
    step();
    idle_inputs();
    step();
    n_tests++;
    if (bus.rs_en_out !== 1'b0) begin n_fail++; $display("FAIL wake_wait: got %0b exp 0", bus.rs_en_out); end
    bus.cdb_lsb_en_in    = 1'b1;
    bus.cdb_lsb_dest_in  = 4'd6;
    bus.cdb_lsb_value_in = 32'h20;
    step();
    idle_inputs();
    n_tests++;
    if (bus.rs_en_out !== 1'b0) begin n_fail++; $display("FAIL wake_early: got %0b exp 0", bus.rs_en_out); end
    step();
    n_tests++;
    if (bus.rs_en_out !== 1'b1 || bus.rs_vj_out !== 32'h20)
      begin n_fail++; $display("FAIL wake_issue: en %0b vj %h exp 1 20", bus.rs_en_out, bus.rs_vj_out); end
    n_tests++;
    if (bus.rs_A_out !== 32'd10 || bus.rs_dest_out !== 4'd4 || bus.rs_inst_type_out !== TYPE_ADDI)
      begin n_fail++; $display("FAIL wake_fields: A %0d dest %0d type %0d exp 10 4 %0d", bus.rs_A_out, bus.rs_dest_out, bus.rs_inst_type_out, TYPE_ADDI); end
    step();
  endtask

  task automatic test_bypass();
    drive_dispatch(32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd2, 32'd0, 4'd7, 32'h200, TYPE_SUB);
    bus.cdb_alu_en_in    = 1'b1;
    bus.cdb_alu_dest_in  = 4'd2;
    bus.cdb_alu_value_in = 32'd9;
    step();
    idle_inputs();
    step();
    n_tests++;
    if (bus.rs_en_out !== 1'b1 || bus.rs_vk_out !== 32'd9 || bus.rs_vj_out !== 32'd1)
      begin n_fail++; $display("FAIL bypass: en %0b vj %0d vk %0d exp 1 1 9", bus.rs_en_out, bus.rs_vj_out, bus.rs_vk_out); end
    n_tests++;
    if (bus.rs_dest_out !== 4'd7) begin n_fail++; $display("FAIL bypass_dest: got %0d exp 7", bus.rs_dest_out); end
    step();
  endtask

  task automatic test_rdy_hold();
    drive_dispatch(32'hAA, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd2, 32'h300, TYPE_BEQ);
    step();
    idle_inputs();
    rdy_in = 1'b0;
    step();
    step();
    n_tests++;
    if (bus.rs_en_out !== 1'b0) begin n_fail++; $display("FAIL rdy_frozen: got %0b exp 0", bus.rs_en_out); end
    rdy_in = 1'b1;
    step();
    n_tests++;
    if (bus.rs_en_out !== 1'b1 || bus.rs_vj_out !== 32'hAA || bus.rs_dest_out !== 4'd2)
      begin n_fail++; $display("FAIL rdy_issue: en %0b vj %h dest %0d exp 1 aa 2", bus.rs_en_out, bus.rs_vj_out, bus.rs_dest_out); end
    rdy_in = 1'b0;
    step();
    n_tests++;
    if (bus.rs_en_out !== 1'b1) begin n_fail++; $display("FAIL rdy_outhold: got %0b exp 1", bus.rs_en_out); end
    rdy_in = 1'b1;
    step();
    n_tests++;
    if (bus.rs_en_out !== 1'b0) begin n_fail++; $display("FAIL rdy_resume: got %0b exp 0", bus.rs_en_out); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      drive_dispatch(32'd0, 32'd0, 1'b1, 4'(i + 8), 1'b0, 4'd0, 32'd0, 4'(i), 32'(i), TYPE_ADD);
      step();
    end
    idle_inputs();
    n_tests++;
    if (bus.rs_full_out !== 1'b1) begin n_fail++; $display("FAIL full_set: got %0b exp 1", bus.rs_full_out); end
    drive_dispatch(32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd15, 32'h0, TYPE_ADD);
    step();
    idle_inputs();
    step();
    n_tests++;
    if (bus.rs_en_out !== 1'b0) begin n_fail++; $display("FAIL full_ignore: got %0b exp 0", bus.rs_en_out); end
    n_tests++;
    if (bus.rs_full_out !== 1'b1) begin n_fail++; $display("FAIL full_still: got %0b exp 1", bus.rs_full_out); end
    bus.cdb_alu_en_in    = 1'b1;
    bus.cdb_alu_dest_in  = 4'd13;
    bus.cdb_alu_value_in = 32'h55;
    step();
    idle_inputs();
    n_tests++;
    if (bus.rs_full_out !== 1'b1) begin n_fail++; $display("FAIL full_woken: got %0b exp 1", bus.rs_full_out); end
    step();
    n_tests++;
    if (bus.rs_en_out !== 1'b1 || bus.rs_dest_out !== 4'd5 || bus.rs_vj_out !== 32'h55)
      begin n_fail++; $display("FAIL full_issue: en %0b dest %0d vj %h exp 1 5 55", bus.rs_en_out, bus.rs_dest_out, bus.rs_vj_out); end
    n_tests++;
    if (bus.rs_full_out !== 1'b0) begin n_fail++; $display("FAIL full_clear: got %0b exp 0", bus.rs_full_out); end
    bus.rob_flush_in = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_priority();
    drive_dispatch(32'd0, 32'd0, 1'b1, 4'd1, 1'b0, 4'd0, 32'd0, 4'd8,  32'h0, TYPE_ADD); step();
    drive_dispatch(32'd0, 32'd3, 1'b1, 4'd7, 1'b0, 4'd0, 32'd0, 4'd9,  32'h4, TYPE_ADD); step();
    drive_dispatch(32'd0, 32'd0, 1'b1, 4'd1, 1'b0, 4'd0, 32'd0, 4'd10, 32'h8, TYPE_ADD); step();
    drive_dispatch(32'd0, 32'd0, 1'b1, 4'd1, 1'b0, 4'd0, 32'd0, 4'd11, 32'hC, TYPE_ADD); step();
    drive_dispatch(32'd4, 32'd0, 1'b0, 4'd0, 1'b1, 4'd7, 32'd0, 4'd12, 32'h10, TYPE_JAL); step();
    idle_inputs();
    bus.cdb_alu_en_in    = 1'b1;
    bus.cdb_alu_dest_in  = 4'd7;
    bus.cdb_alu_value_in = 32'h77;
    step();
    idle_inputs();
    n_tests++;
    if (bus.rs_en_out !== 1'b0) begin n_fail++; $display("FAIL prio_early: got %0b exp 0", bus.rs_en_out); end
    step();
    n_tests++;
    if (bus.rs_en_out !== 1'b1 || bus.rs_dest_out !== 4'd9 || bus.rs_vj_out !== 32'h77)
      begin n_fail++; $display("FAIL prio_first: en %0b dest %0d vj %h exp 1 9 77", bus.rs_en_out, bus.rs_dest_out, bus.rs_vj_out); end
    step();
    n_tests++;
    if (bus.rs_en_out !== 1'b1 || bus.rs_dest_out !== 4'd12 || bus.rs_vk_out !== 32'h77)
      begin n_fail++; $display("FAIL prio_second: en %0b dest %0d vk %h exp 1 12 77", bus.rs_en_out, bus.rs_dest_out, bus.rs_vk_out); end
    step();
    n_tests++;
    if (bus.rs_en_out !== 1'b0) begin n_fail++; $display("FAIL prio_done: got %0b exp 0", bus.rs_en_out); end
  endtask

  // Entries 0,2,3 remain pending from the priority scenario; two more make five
  task automatic test_flush();
    drive_dispatch(32'd0, 32'd0, 1'b1, 4'd1, 1'b0, 4'd0, 32'd0, 4'd13, 32'h0, TYPE_ADD); step();
    drive_dispatch(32'd0, 32'd0, 1'b1, 4'd1, 1'b0, 4'd0, 32'd0, 4'd14, 32'h0, TYPE_ADD); step();
    drive_dispatch(32'd6, 32'd6, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd15, 32'h0, TYPE_ADD);
    bus.rob_flush_in = 1'b1;
    step();
    idle_inputs();
    n_tests++;
    if (bus.rs_full_out !== 1'b0 || bus.rs_en_out !== 1'b0)
      begin n_fail++; $display("FAIL flush_now: full %0b en %0b exp 0 0", bus.rs_full_out, bus.rs_en_out); end
    bus.cdb_alu_en_in    = 1'b1;
    bus.cdb_alu_dest_in  = 4'd1;
    bus.cdb_alu_value_in = 32'h11;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (bus.rs_en_out !== 1'b0) begin n_fail++; $display("FAIL flush_quiet%0d: got %0b exp 0", i, bus.rs_en_out); end
    end
  endtask

  task automatic test_async_reset();
    drive_dispatch(32'h99, 32'h1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd6, 32'h500, TYPE_JALR);
    step();
    idle_inputs();
    step();
    n_tests++;
    if (bus.rs_en_out !== 1'b1 || bus.rs_vj_out !== 32'h99)
      begin n_fail++; $display("FAIL areset_pre: en %0b vj %h exp 1 99", bus.rs_en_out, bus.rs_vj_out); end
    #2;
    rst_n_in = 1'b0;
    #1;
    n_tests++;
    if (bus.rs_en_out !== 1'b0 || bus.rs_vj_out !== 32'd0 || bus.rs_pc_out !== 32'd0 || bus.rs_full_out !== 1'b0)
      begin n_fail++; $display("FAIL areset_clear: en %0b vj %h pc %h full %0b exp 0", bus.rs_en_out, bus.rs_vj_out, bus.rs_pc_out, bus.rs_full_out); end
    #2;
    rst_n_in = 1'b1;
    step();
    n_tests++;
    if (bus.rs_en_out !== 1'b0) begin n_fail++; $display("FAIL areset_after: got %0b exp 0", bus.rs_en_out); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_add();
    test_wakeup();
    test_bypass();
    test_rdy_hold();
    test_full();
    test_priority();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
